// File: rtl/pwm_duty_sequencer.sv
// Duty/max_value sequencer feeding pwm_module. It mirrors the PWM period counter
// so that duty and max_value only change on period boundaries.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no command active, profile output held
// APPLY    | command latched, waiting for the next period_tick to apply it
// RAMP     | stepping duty by one per step event toward target
// BRTH_UP  | breathe, duty rising toward target
// BRTH_DN  | breathe, duty falling toward zero
module pwm_duty_sequencer #(
  parameter int bit_width  = 3,
  parameter int rate_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_mode,
  input  logic [bit_width-1:0]  cfg_target,
  input  logic [bit_width-1:0]  cfg_max,
  input  logic [rate_width-1:0] cfg_rate,
  output logic [bit_width-1:0]  duty,
  output logic [bit_width-1:0]  max_value,
  output logic                  period_tick,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_RAMP, S_BRTH_UP, S_BRTH_DN
  } state_t;

  localparam logic [1:0] M_HOLD    = 2'b00;
  localparam logic [1:0] M_RAMP    = 2'b01;
  localparam logic [1:0] M_BREATHE = 2'b10;

  state_t                state_q, state_d;
  logic [bit_width:0]    pcnt_q, pcnt_d;
  logic [rate_width-1:0] rcnt_q, rcnt_d;
  logic [bit_width-1:0]  duty_q, duty_d;
  logic [bit_width-1:0]  max_q, max_d;
  logic [1:0]            mode_q, mode_d;
  logic [bit_width-1:0]  target_q, target_d;
  logic [bit_width-1:0]  cmax_q, cmax_d;
  logic [rate_width-1:0] rate_q, rate_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  step;
  logic                  accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pcnt_q   <= '0;
      rcnt_q   <= '0;
      duty_q   <= '0;
      max_q    <= '1;
      mode_q   <= '0;
      target_q <= '0;
      cmax_q   <= '0;
      rate_q   <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      rcnt_q   <= rcnt_d;
      duty_q   <= duty_d;
      max_q    <= max_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      cmax_q   <= cmax_d;
      rate_q   <= rate_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    period_tick = (pcnt_q == {1'b0, max_q});
    step        = period_tick && (rcnt_q == rate_q);
    accept      = cfg_valid && ready_q;

    state_d  = state_q;
    pcnt_d   = period_tick ? '0 : pcnt_q + 1'b1;
    rcnt_d   = step ? '0 : (period_tick ? rcnt_q + 1'b1 : rcnt_q);
    duty_d   = duty_q;
    max_d    = max_q;
    mode_d   = mode_q;
    target_d = target_q;
    cmax_d   = cmax_q;
    rate_d   = rate_q;
    done_d   = 1'b0;

    // An accepted command always wins, even over a breathe step on the same edge.
    if (accept) begin
      mode_d   = cfg_mode;
      target_d = (cfg_target > cfg_max) ? cfg_max : cfg_target;
      cmax_d   = cfg_max;
      rate_d   = cfg_rate;
      state_d  = S_APPLY;
    end else begin
      unique case (state_q)
        S_APPLY: if (period_tick) begin
          max_d = cmax_q;
          unique case (mode_q)
            M_HOLD: begin
              duty_d  = target_q;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
            M_RAMP: begin
              duty_d  = (duty_q > cmax_q) ? cmax_q : duty_q;
              state_d = S_RAMP;
            end
            M_BREATHE: begin
              duty_d  = (duty_q > target_q) ? target_q : duty_q;
              state_d = S_BRTH_UP;
            end
            default: begin
              duty_d  = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_RAMP: if (step) begin
          if (duty_q == target_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            duty_d = (duty_q < target_q) ? duty_q + 1'b1 : duty_q - 1'b1;
            if (duty_d == target_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_BRTH_UP: if (step) begin
          if (target_q == '0) begin
            duty_d = '0;
          end else if (duty_q < target_q) begin
            duty_d = duty_q + 1'b1;
          end else begin
            duty_d  = duty_q - 1'b1;
            state_d = S_BRTH_DN;
          end
        end
        S_BRTH_DN: if (step) begin
          if (duty_q != '0) begin
            duty_d = duty_q - 1'b1;
          end else begin
            if (target_q != '0) duty_d = duty_q + 1'b1;
            state_d = S_BRTH_UP;
          end
        end
        default: ;
      endcase
    end

    if ((state_d == S_RAMP || state_d == S_BRTH_UP) && state_d != state_q)
      rcnt_d = '0;

    ready_d = (state_d == S_IDLE) || (state_d == S_BRTH_UP) || (state_d == S_BRTH_DN);
  end

  assign cfg_ready = ready_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign duty      = duty_q;
  assign max_value = max_q;

endmodule
